// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and datapath mux select codes.
package kgp_risc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] SEL_R0 = 2'b00;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;

  function automatic logic [2:0] sel_to_onehot(input logic [1:0] s);
    logic [2:0] oh;
    oh = 3'b000;
    case (s)
      SEL_R0:  oh = 3'b001;
      SEL_R1:  oh = 3'b010;
      SEL_R2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: the search starts just after the previous winner.
module rr_pick3
  import kgp_risc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  always_comb begin
    winner = SEL_R0;
    valid  = |req;
    case (last)
      SEL_R0: begin
        if (req[1])      winner = SEL_R1;
        else if (req[2]) winner = SEL_R2;
        else             winner = SEL_R0;
      end
      SEL_R1: begin
        if (req[2])      winner = SEL_R2;
        else if (req[0]) winner = SEL_R0;
        else             winner = SEL_R1;
      end
      default: begin
        if (req[0])      winner = SEL_R0;
        else if (req[1]) winner = SEL_R1;
        else             winner = SEL_R2;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared memory path with three requesters and a BUSY timeout.
module mem_port_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       mem_ack,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_t state;
  logic [7:0] cnt;
  logic [1:0] last;
  logic [1:0] pick;
  logic       pick_valid;

  rr_pick3 u_pick (
    .req    (req),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  // sel doubles as the owner index while BUSY; it is only updated on a new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= 3'b000;
      sel       <= SEL_R0;
      mem_valid <= 1'b0;
      done      <= 3'b000;
      err       <= 1'b0;
      cnt       <= 8'd0;
      last      <= SEL_R2;
    end else begin
      done <= 3'b000;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state     <= ST_BUSY;
            sel       <= pick;
            gnt       <= sel_to_onehot(pick);
            mem_valid <= 1'b1;
            cnt       <= 8'd1;
          end
        end
        ST_BUSY: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (mem_ack) begin
            done      <= gnt;
            gnt       <= 3'b000;
            mem_valid <= 1'b0;
            last      <= sel;
            cnt       <= 8'd0;
            state     <= ST_IDLE;
          end else if (cnt == TIMEOUT_CNT) begin
            err       <= 1'b1;
            gnt       <= 3'b000;
            mem_valid <= 1'b0;
            last      <= sel;
            cnt       <= 8'd0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model feeds an expected-output queue.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       mem_ack = 1'b0;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       mem_valid;
  logic [2:0] done;
  logic       err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mem_ack   (mem_ack),
    .sel       (sel),
    .gnt       (gnt),
    .mem_valid (mem_valid),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mv;
    logic [2:0] done;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: who owns the path, how long it has held it, who was served last.
  int         m_busy = 0;
  int         m_owner = 0;
  int         m_age = 0;
  int         m_last = 2;
  logic [2:0] e_gnt = 3'b000;
  logic [1:0] e_sel = 2'b00;
  logic       e_mv = 1'b0;
  logic [2:0] e_done = 3'b000;
  logic       e_err = 1'b0;

  task automatic model_step(input logic [2:0] r, input logic a, input logic rs);
    int w;
    e_done = 3'b000;
    e_err  = 1'b0;
    if (rs) begin
      m_busy = 0; m_age = 0; m_last = 2;
      e_gnt = 3'b000; e_sel = 2'b00; e_mv = 1'b0;
    end else if (m_busy == 0) begin
      w = -1;
      for (int i = 1; i <= 3; i++) begin
        int c;
        c = (m_last + i) % 3;
        if (w < 0 && r[c]) w = c;
      end
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_age = 1;
        e_gnt = 3'(1 << w); e_sel = 2'(w); e_mv = 1'b1;
      end
    end else if (a || m_age == TIMEOUT) begin
      if (a) e_done = 3'(1 << m_owner);
      else   e_err = 1'b1;
      e_gnt = 3'b000; e_mv = 1'b0;
      m_last = m_owner; m_busy = 0; m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic a, input logic rs);
    exp_t x;
    @(negedge clk);
    req = r; mem_ack = a; rst = rs;
    model_step(r, a, rs);
    x.gnt = e_gnt; x.sel = e_sel; x.mv = e_mv; x.done = e_done; x.err = e_err;
    q.push_back(x);
  endtask

  // Requesters drop their line once served (done or err); ack_at=0 never acks.
  task automatic run_req(input logic [2:0] r0, input int ack_at, input int ncyc, input bit sticky);
    logic [2:0] r;
    int own;
    r = r0;
    for (int k = 0; k < ncyc; k++) begin
      own = m_owner;
      drive(r, (m_busy != 0 && m_age == ack_at), 1'b0);
      if (!sticky) begin
        r = r & ~e_done;
        if (e_err) r[own] = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        n_vec++;
        if ({gnt, sel, mem_valid, done, err} !== x) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got gnt=%b sel=%b mv=%b done=%b err=%b, want gnt=%b sel=%b mv=%b done=%b err=%b",
                   $time, gnt, sel, mem_valid, done, err, x.gnt, x.sel, x.mv, x.done, x.err);
        end
        n_vec++;
        if (sel === 2'b11 || !$onehot0(gnt)) begin
          n_bad++;
          $display("FAIL legal_grant t=%0t: got sel=%b gnt=%b, want sel!=11 and gnt at most one-hot",
                   $time, sel, gnt);
        end
      end
    end
  end

  initial begin
    logic [2:0] pend;
    int own;
    int ack_pct;
    drive(3'b000, 1'b0, 1'b1);
    drive(3'b000, 1'b0, 1'b1);
    // ack while idle with no requests
    repeat (3) drive(3'b000, 1'b1, 1'b0);
    // all three requesting, ack on first BUSY cycle: grants 0,1,2,0
    run_req(3'b111, 1, 8, 1'b1);
    drive(3'b000, 1'b0, 1'b0);
    // single requester 1, ack on third BUSY cycle
    run_req(3'b010, 3, 7, 1'b0);
    // timeout on requester 2, then 0 and 2 compete
    run_req(3'b100, 0, 7, 1'b0);
    run_req(3'b101, 1, 6, 1'b0);
    // ack exactly on the TIMEOUT-th BUSY cycle
    run_req(3'b001, TIMEOUT, 7, 1'b0);
    // reset mid-transfer
    drive(3'b001, 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b1);
    drive(3'b000, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 1'b0);
    // randomized traffic with held requests, occasional drops and resets
    pend = 3'b000;
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = 10 + 15 * blk;
      for (int k = 0; k < 500; k++) begin
        logic a;
        logic rs;
        for (int i = 0; i < 3; i++)
          if ($urandom_range(0, 99) < 20) pend[i] = 1'b1;
        if ($urandom_range(0, 99) < 3) pend[$urandom_range(0, 2)] = 1'b0;
        a  = ($urandom_range(0, 99) < ack_pct);
        rs = ($urandom_range(0, 199) == 0);
        own = m_owner;
        drive(pend, a, rs);
        pend = pend & ~e_done;
        if (e_err) pend[own] = 1'b0;
      end
    end
    drive(3'b000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
